// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush sequencer.
//  - Exception codes reported by the MEM stage.
//  - Stall bus patterns. Bit 0 is PC and bit 5 is WB; a 1 holds that stage.
//  - FSM state encoding.
package pipeline_ctrl_pkg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned DATA_W  = 32;

    // Exception codes; zero means no exception
    localparam logic [DATA_W-1:0] EXC_NONE         = 32'h0000_0000;
    localparam logic [DATA_W-1:0] EXC_INT          = 32'h0000_0001;
    localparam logic [DATA_W-1:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [DATA_W-1:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [DATA_W-1:0] EXC_OV           = 32'h0000_000c;
    localparam logic [DATA_W-1:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [DATA_W-1:0] EXC_ERET         = 32'h0000_000e;

    // Stall bus patterns, ordered from the least to the most restrictive
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Merges the stage requests into one stall pattern; the latest stage that
    // requests a stall wins, because it must also hold every stage before it.
    function automatic logic [STALL_W-1:0] stall_pattern(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [STALL_W-1:0] pat;
        pat = STALL_NONE;
        if (req_mem) begin
            pat = STALL_MEM;
        end else if (req_ex) begin
            pat = STALL_EX;
        end else if (req_id) begin
            pat = STALL_ID;
        end else if (req_if) begin
            pat = STALL_IF;
        end
        return pat;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter. It stops at all-ones and does not wrap.
//  clk, rst_n : clock and asynchronous active-low reset
//  clr_i      : synchronous clear; it takes priority over inc_i
//  inc_i      : add one unless the counter is already saturated
//  cnt_o      : current count
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//  clk, rst_n        : clock and asynchronous active-low reset
//  stallreq_if/id/ex/mem : stall requests from each stage
//  exception_type_i  : exception code of the MEM-stage instruction (0 = none)
//  cp0_epc_i         : CP0 EPC, used as the ERET target
//  cnt_clr           : synchronous clear of both performance counters
//  stall             : combinational stall bus, [0]PC .. [5]WB, 1 = hold
//  flush             : registered one-cycle flush of all pipeline registers
//  new_pc            : registered redirect target, valid while flush is high
//  stall_cycles_o    : saturating count of stalled RUN cycles
//  flush_count_o     : saturating count of accepted exceptions
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic [DATA_W-1:0]   exception_type_i,
    input  logic [DATA_W-1:0]   cp0_epc_i,
    input  logic                cnt_clr,
    output logic [STALL_W-1:0]  stall,
    output logic                flush,
    output logic [DATA_W-1:0]   new_pc,
    output logic [CNT_W-1:0]    stall_cycles_o,
    output logic [CNT_W-1:0]    flush_count_o
);

    state_e              state_q, state_d;
    logic                flush_q, flush_d;
    logic [DATA_W-1:0]   new_pc_q, new_pc_d;
    logic [STALL_W-1:0]  stall_c;
    logic                accept_c;
    logic                stall_inc_c;

    // An exception waits while MEM is still stalled so the faulting access finishes first
    assign accept_c = (state_q == ST_RUN) && (exception_type_i != EXC_NONE) && !stallreq_mem;

    // Next state, flush/redirect registers and the stall bus
    always_comb begin
        state_d     = state_q;
        flush_d     = 1'b0;
        new_pc_d    = new_pc_q;
        stall_c     = STALL_NONE;
        stall_inc_c = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (accept_c) begin
                    // Hold everything so the faulting instruction never retires
                    stall_c  = STALL_ALL;
                    flush_d  = 1'b1;
                    new_pc_d = (exception_type_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
                    state_d  = ST_FLUSH;
                end else begin
                    stall_c     = stall_pattern(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
                    stall_inc_c = (stall_c != STALL_NONE);
                end
            end
            ST_FLUSH: begin
                // Requests and exceptions are ignored while the pipeline is being cleared
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign stall  = stall_c;
    assign flush  = flush_q;
    assign new_pc = new_pc_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (stall_inc_c),
        .cnt_o (stall_cycles_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (accept_c),
        .cnt_o (flush_count_o)
    );

endmodule
